// File: rtl/m68k_bus_ctrl.sv
// m68k_bus_ctrl: 68000 bus controller for fx68k.
// It generates the Phi1/Phi2 enables and decodes the address into regions.
// It counts per-region wait states and stretches on external ready.
// It drives DTACKn or BERRn, muxes the read data and issues select and write strobes.
module m68k_bus_ctrl #(
  parameter int unsigned c_slowdown     = 0,
  parameter int unsigned c_regions      = 4,
  parameter int unsigned c_dec_lo       = 15,
  parameter int unsigned c_dec_hi       = 17,
  parameter logic [31:0] c_wait         = 32'h0000_0000,
  parameter int unsigned c_berr_timeout = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    phi1,
  output logic                    phi2,
  input  logic                    cpu_as_n,
  input  logic                    cpu_uds_n,
  input  logic                    cpu_lds_n,
  input  logic                    cpu_rw,
  input  logic [23:1]             cpu_a,
  output logic [15:0]             cpu_din,
  output logic                    dtack_n,
  output logic                    berr_n,
  input  logic [16*c_regions-1:0] region_din,
  input  logic [c_regions-1:0]    region_ready,
  output logic [c_regions-1:0]    sel,
  output logic [c_regions-1:0]    we,
  output logic                    ub,
  output logic                    lb
);

  localparam int unsigned c_rw = (c_regions > 1) ? $clog2(c_regions) : 1;
  localparam int unsigned c_fw = c_dec_hi - c_dec_lo + 1;
  localparam int unsigned c_cw = (c_slowdown > 0) ? c_slowdown : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BERR} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_phi1;
  logic                   r_phi2;
  logic [c_rw-1:0]        r_region;
  logic                   r_rw;
  logic [3:0]             r_wcnt;
  logic [31:0]            r_tcnt;
  logic [c_regions-1:0]   r_we;
  logic                   r_ub;
  logic                   r_lb;
  logic [c_fw-1:0]        w_field;
  logic [c_rw-1:0]        w_region;
  logic [3:0]             w_wait_load;
  logic [c_regions-1:0]   w_onehot;
  logic                   w_ready;
  logic [15:0]            w_din;
  logic                   w_accept;
  logic                   w_ack_entry;
  logic                   w_unused_addr;

  // Address bits outside the region field are decoded elsewhere in the system.
  assign w_unused_addr = &{1'b0, cpu_a};

  // Enable generator: plain toggle at full speed, otherwise a free-running divider.
  generate
    if (c_slowdown == 0) begin : g_fast
      // Phi1 toggles every clk; phi2 trails it by one clk.
      always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!reset_n) begin
          r_phi1 <= 1'b0;
          r_phi2 <= 1'b0;
        end else begin
          r_phi1 <= ~r_phi1;
          r_phi2 <= r_phi1;
        end
      end
    end else begin : g_div
      localparam logic [c_cw-1:0] c_half = c_cw'(1 << (c_cw - 1));
      logic [c_cw-1:0] r_cnt;
      // Divider: phi1 at count 0, phi2 half a period later.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_cnt  <= '0;
          r_phi1 <= 1'b0;
          r_phi2 <= 1'b0;
        end else begin
          r_cnt  <= r_cnt + c_cw'(1);
          r_phi1 <= (r_cnt == '0);
          r_phi2 <= (r_cnt == c_half);
        end
      end
    end
  endgenerate

  assign phi1 = r_phi1;
  assign phi2 = r_phi2;

  // Region decode: field values past the last region all map to the last region.
  assign w_field = cpu_a[c_dec_hi:c_dec_lo];
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_region    = c_rw'(w_field);
    w_wait_load = 4'd0;
    if (32'(w_field) >= c_regions - 1) w_region = c_rw'(c_regions - 1);
    for (int i = 0; i < c_regions; i++)
      if (w_region == c_rw'(i)) w_wait_load = c_wait[4*i +: 4];
  end

  // Latched-region one-hot plus its ready bit and read data.
  always_comb begin
    w_onehot = '0;
    w_ready  = 1'b0;
    w_din    = 16'h0000;
    for (int i = 0; i < c_regions; i++) begin
      w_onehot[i] = (r_region == c_rw'(i));
      if (w_onehot[i]) begin
        w_ready = region_ready[i];
        w_din   = region_din[16*i +: 16];
      end
    end
  end

  // Next-state logic: ACK beats timeout when both land on the same phi2.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_ack_entry  = 1'b0;
    unique case (r_state)
      S_IDLE: if (!cpu_as_n) begin
        w_state_next = S_WAIT;
        w_accept     = 1'b1;
      end
      S_WAIT: begin
        if (cpu_as_n) begin
          w_state_next = S_IDLE;
        end else if (r_phi2) begin
          if (r_wcnt == 4'd0 && w_ready) begin
            w_state_next = S_ACK;
            w_ack_entry  = 1'b1;
          end else if (c_berr_timeout != 0 && r_tcnt + 32'd1 == c_berr_timeout) begin
            w_state_next = S_BERR;
          end
        end
      end
      S_ACK, S_BERR: if (cpu_as_n) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Cycle registers: latch on accept, count on phi2 in WAIT, capture strobes on ACK entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_region <= '0;
      r_rw     <= 1'b1;
      r_wcnt   <= 4'd0;
      r_tcnt   <= 32'd0;
      r_we     <= '0;
      r_ub     <= 1'b0;
      r_lb     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_we    <= '0;
      if (w_accept) begin
        r_region <= w_region;
        r_rw     <= cpu_rw;
        r_wcnt   <= w_wait_load;
        r_tcnt   <= 32'd0;
      end
      if (r_state == S_WAIT && r_phi2) begin
        if (r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
        r_tcnt <= r_tcnt + 32'd1;
      end
      if (w_ack_entry) begin
        r_ub <= ~cpu_uds_n;
        r_lb <= ~cpu_lds_n;
        if (!r_rw) r_we <= w_onehot;
      end
    end
  end

  assign sel     = (r_state != S_IDLE) ? w_onehot : '0;
  assign we      = r_we;
  assign ub      = r_ub;
  assign lb      = r_lb;
  assign dtack_n = (r_state != S_ACK);
  assign berr_n  = (r_state != S_BERR);
  assign cpu_din = (r_state != S_IDLE) ? w_din : 16'hFFFF;

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Testbench for m68k_bus_ctrl: directed scenarios plus randomized bus cycles
// checked against a phi2-counting behavioural model.
module tb_m68k_bus_ctrl;

  localparam int unsigned  SLOW    = 3;
  localparam int unsigned  REGIONS = 4;
  localparam logic [31:0]  WAITS   = 32'h0000_0300;
  localparam int unsigned  TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw;
  logic [23:1] cpu_a;
  logic [63:0] region_din;
  logic [3:0]  region_ready;
  logic        phi1, phi2, dtack_n, berr_n, ub, lb;
  logic [15:0] cpu_din;
  logic [3:0]  sel, we;
  logic        phi1_f, phi2_f, dtack_n_f, berr_n_f, ub_f, lb_f;
  logic [15:0] cpu_din_f;
  logic [3:0]  sel_f, we_f;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  m68k_bus_ctrl #(.c_slowdown(SLOW), .c_regions(REGIONS), .c_dec_lo(15), .c_dec_hi(17),
                  .c_wait(WAITS), .c_berr_timeout(TIMEOUT)) u_dut (
    .clk(clk), .reset_n(reset_n), .phi1(phi1), .phi2(phi2),
    .cpu_as_n(cpu_as_n), .cpu_uds_n(cpu_uds_n), .cpu_lds_n(cpu_lds_n), .cpu_rw(cpu_rw),
    .cpu_a(cpu_a), .cpu_din(cpu_din), .dtack_n(dtack_n), .berr_n(berr_n),
    .region_din(region_din), .region_ready(region_ready), .sel(sel), .we(we), .ub(ub), .lb(lb)
  );

  // Full-speed instance, used only to observe the undivided enables.
  m68k_bus_ctrl #(.c_slowdown(0), .c_regions(REGIONS)) u_dut_fast (
    .clk(clk), .reset_n(reset_n), .phi1(phi1_f), .phi2(phi2_f),
    .cpu_as_n(1'b1), .cpu_uds_n(1'b1), .cpu_lds_n(1'b1), .cpu_rw(1'b1),
    .cpu_a(cpu_a), .cpu_din(cpu_din_f), .dtack_n(dtack_n_f), .berr_n(berr_n_f),
    .region_din(region_din), .region_ready(region_ready), .sel(sel_f), .we(we_f), .ub(ub_f), .lb(lb_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: region index after clamping the 3-bit field at the last region.
  function automatic int model_region(logic [23:0] addr);
    int f;
    f = int'(addr[17:15]);
    return (f >= REGIONS - 1) ? REGIONS - 1 : f;
  endfunction

  function automatic int model_wait(int r);
    return int'((WAITS >> (4 * r)) & 32'hF);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; cpu_as_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1; cpu_rw = 1'b1;
    cpu_a = '0; region_din = '0; region_ready = '1;
    repeat (3) tick();
    n_total++; if (dtack_n !== 1'b1) $display("FAIL rst_dtack got %b want 1", dtack_n); else n_pass++;
    n_total++; if (berr_n !== 1'b1) $display("FAIL rst_berr got %b want 1", berr_n); else n_pass++;
    n_total++; if (sel !== 4'b0) $display("FAIL rst_sel got %b want 0000", sel); else n_pass++;
    n_total++; if (we !== 4'b0) $display("FAIL rst_we got %b want 0000", we); else n_pass++;
    n_total++; if ({ub, lb} !== 2'b00) $display("FAIL rst_ublb got %b want 00", {ub, lb}); else n_pass++;
    n_total++; if ({phi1, phi2, phi1_f, phi2_f} !== 4'b0) $display("FAIL rst_phi got %b want 0000", {phi1, phi2, phi1_f, phi2_f}); else n_pass++;
    n_total++; if (cpu_din !== 16'hFFFF) $display("FAIL rst_din got %h want FFFF", cpu_din); else n_pass++;
  endtask

  // Enables after release: divided phi1 at clk 1,9,17..., phi2 at 5,13,...; fast ones alternate.
  task automatic test_enables();
    reset_n = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      n_total++; if (phi1 !== (n % 8 == 1)) $display("FAIL en_phi1 clk %0d got %b want %b", n, phi1, (n % 8 == 1)); else n_pass++;
      n_total++; if (phi2 !== (n % 8 == 5)) $display("FAIL en_phi2 clk %0d got %b want %b", n, phi2, (n % 8 == 5)); else n_pass++;
      n_total++; if ({phi1_f, phi2_f} !== {n % 2 == 1, n % 2 == 0}) $display("FAIL en_fast clk %0d got %b%b", n, phi1_f, phi2_f); else n_pass++;
    end
  endtask

  // One bus cycle. Ready for the region is low on the first k phi2 enables.
  task automatic run_txn(input logic [23:0] addr, input logic rw, input logic uds_n,
                         input logic lds_n, input int k, input bit release_as);
    logic [15:0] data [4];
    logic [3:0]  exp_sel;
    int          r, p_ack, idx, ph_cnt;
    bit          is_berr, ended;
    r = model_region(addr);
    exp_sel = 4'b0001 << r;
    for (int i = 0; i < 4; i++) begin
      data[i] = 16'($urandom);
      region_din[16*i +: 16] = data[i];
    end
    region_ready = 4'($urandom);
    p_ack   = ((model_wait(r) > k) ? model_wait(r) : k) + 1;
    is_berr = (TIMEOUT != 0) && (p_ack > TIMEOUT);
    idx     = is_berr ? TIMEOUT : p_ack;
    cpu_a = addr[23:1]; cpu_rw = rw; cpu_uds_n = uds_n; cpu_lds_n = lds_n; cpu_as_n = 1'b0;
    tick();
    n_total++; if (sel !== exp_sel) $display("FAIL start_sel got %b want %b", sel, exp_sel); else n_pass++;
    n_total++; if (cpu_din !== data[r]) $display("FAIL start_din got %h want %h", cpu_din, data[r]); else n_pass++;
    ph_cnt = 0;
    ended  = 0;
    for (int c = 0; c < 400 && !ended; c++) begin
      bit ph;
      ph = phi2;
      if (ph) begin
        ph_cnt++;
        region_ready[r] = (ph_cnt > k);
      end
      tick();
      if (ph && ph_cnt == idx) begin
        ended = 1;
        if (is_berr) begin
          n_total++; if ({berr_n, dtack_n} !== 2'b01) $display("FAIL berr_out phi2 %0d got berr_n=%b dtack_n=%b want 0 1", ph_cnt, berr_n, dtack_n); else n_pass++;
          n_total++; if (we !== 4'b0) $display("FAIL berr_we got %b want 0000", we); else n_pass++;
        end else begin
          n_total++; if ({berr_n, dtack_n} !== 2'b10) $display("FAIL ack_out phi2 %0d got berr_n=%b dtack_n=%b want 1 0", ph_cnt, berr_n, dtack_n); else n_pass++;
          n_total++; if (we !== (rw ? 4'b0 : exp_sel)) $display("FAIL ack_we got %b want %b", we, rw ? 4'b0 : exp_sel); else n_pass++;
          n_total++; if ({ub, lb} !== {~uds_n, ~lds_n}) $display("FAIL ack_ublb got %b want %b", {ub, lb}, {~uds_n, ~lds_n}); else n_pass++;
          n_total++; if (cpu_din !== data[r]) $display("FAIL ack_din got %h want %h", cpu_din, data[r]); else n_pass++;
        end
        n_total++; if (sel !== exp_sel) $display("FAIL end_sel got %b want %b", sel, exp_sel); else n_pass++;
      end else if (ph) begin
        n_total++; if ({berr_n, dtack_n, we} !== 6'b110000) $display("FAIL wait_early phi2 %0d got berr_n=%b dtack_n=%b we=%b", ph_cnt, berr_n, dtack_n, we); else n_pass++;
      end
    end
    if (!ended) begin
      n_total++;
      $display("FAIL txn_timeout saw %0d phi2 want %0d", ph_cnt, idx);
    end
    tick();
    n_total++; if (we !== 4'b0) $display("FAIL hold_we got %b want 0000", we); else n_pass++;
    n_total++; if ({berr_n, dtack_n} !== (is_berr ? 2'b01 : 2'b10)) $display("FAIL hold_out got %b%b", berr_n, dtack_n); else n_pass++;
    if (release_as) begin
      cpu_as_n = 1'b1;
      tick();
      n_total++; if ({berr_n, dtack_n} !== 2'b11) $display("FAIL rel_out got berr_n=%b dtack_n=%b want 1 1", berr_n, dtack_n); else n_pass++;
      n_total++; if (sel !== 4'b0) $display("FAIL rel_sel got %b want 0000", sel); else n_pass++;
      n_total++; if (cpu_din !== 16'hFFFF) $display("FAIL rel_din got %h want FFFF", cpu_din); else n_pass++;
    end
  endtask

  task automatic test_read();        run_txn(24'h008000, 1'b1, 1'b0, 1'b0, 0, 1'b1);   endtask
  task automatic test_wait_write();  run_txn(24'h010000, 1'b0, 1'b0, 1'b1, 0, 1'b1);   endtask
  task automatic test_clamp_ready(); run_txn(24'h038000, 1'b1, 1'b0, 1'b0, 5, 1'b1);   endtask
  task automatic test_berr();        run_txn(24'h000000, 1'b0, 1'b0, 1'b0, 100, 1'b1); endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++)
      run_txn(24'($urandom) & 24'hFFFFFE, 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 9)), 1'b1);
  endtask

  task automatic test_reset_in_ack();
    run_txn(24'h008000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    reset_n = 1'b0;
    tick();
    n_total++; if (dtack_n !== 1'b1) $display("FAIL rack_dtack got %b want 1", dtack_n); else n_pass++;
    n_total++; if (sel !== 4'b0) $display("FAIL rack_sel got %b want 0000", sel); else n_pass++;
    n_total++; if ({phi1, phi2} !== 2'b00) $display("FAIL rack_phi got %b want 00", {phi1, phi2}); else n_pass++;
    cpu_as_n = 1'b1;
    reset_n  = 1'b1;
    test_read();
  endtask

  initial begin
    test_reset();
    test_enables();
    test_read();
    test_wait_write();
    test_clamp_ready();
    test_berr();
    test_random();
    test_reset_in_ack();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
